// File: rtl/eib_pkg.sv
// Shared definitions for the nested external interrupt block: register map,
// cause-word layout and the fixed-priority encoder.
package eib_pkg;

  localparam logic [11:0] EIB_RA    = 12'hfff;
  localparam logic [11:0] EIB_ISR   = 12'hffe;
  localparam logic [11:0] EIB_IMR   = 12'hffd;
  localparam logic [11:0] EIB_MODE  = 12'hffc;
  localparam logic [11:0] EIB_CAUSE = 12'hffb;
  localparam logic [11:0] EIB_STAT  = 12'hffa;

  localparam int unsigned CAUSE_NONE = 31;

  // Lowest set index wins (line 0 is highest priority); 0 when nothing is set.
  function automatic logic [4:0] prio_enc(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/eib_frame_stack.sv
// Interrupt frame storage: saved return address plus the mask in force
// before the frame was entered. Storage is not reset; depth gates visibility.
module eib_frame_stack
  import eib_pkg::*;
#(
  parameter int unsigned IRQ_COUNT  = 32,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] wr_idx,
  input  logic [31:0]           wr_ra,
  input  logic [IRQ_COUNT-1:0]  wr_imr,
  input  logic [DEPTH_BITS-1:0] rd_idx,
  output logic [31:0]           rd_ra,
  output logic [IRQ_COUNT-1:0]  rd_imr
);

  localparam int unsigned MAX_DEPTH = 1 << DEPTH_BITS;

  logic [31:0]          ra_mem  [MAX_DEPTH];
  logic [IRQ_COUNT-1:0] imr_mem [MAX_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      ra_mem[wr_idx]  <= wr_ra;
      imr_mem[wr_idx] <= wr_imr;
    end
  end

  assign rd_ra  = ra_mem[rd_idx];
  assign rd_imr = imr_mem[rd_idx];

endmodule

// File: rtl/eib_nested.sv
// Nested external interrupt controller on the data bus: edge/level pending
// logic, fixed-priority cause, and a frame stack that masks on push.
module eib_nested
  import eib_pkg::*;
#(
  parameter int unsigned IRQ_COUNT  = 32,
  parameter int unsigned DEPTH_BITS = 4,
  parameter logic [19:0] PAGE       = 20'hfffff
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 strobe,
  input  logic                 rw,
  input  logic [31:0]          d_addr,
  input  logic [31:0]          d_wdata,
  output logic [31:0]          d_rdata,
  input  logic [IRQ_COUNT-1:0] irq,
  output logic                 trap,
  output logic [4:0]           cause
);

  localparam int unsigned DW        = DEPTH_BITS + 1;
  localparam int unsigned MAX_DEPTH = 1 << DEPTH_BITS;

  logic [IRQ_COUNT-1:0] imr, mode, edge_lat, irq_q;
  logic [IRQ_COUNT-1:0] isr, pend, cause_oh, low_mask, edge_set, edge_clr, wdata_n;
  logic [DW-1:0]        depth;
  logic                 ovf, unf;
  logic                 sel, wr_en, rd_en, full, empty, push_ok, pop_ok, any_pend;
  logic [11:0]          off;
  logic [31:0]          st_ra, rd_mux, cause_word;
  logic [IRQ_COUNT-1:0] st_imr;

  // Bus decode and stack bounds
  always_comb begin
    sel     = strobe && (d_addr[31:12] == PAGE);
    off     = d_addr[11:0];
    wr_en   = sel && rw;
    rd_en   = sel && !rw;
    wdata_n = d_wdata[IRQ_COUNT-1:0];
    full    = (depth == DW'(MAX_DEPTH));
    empty   = (depth == '0);
    push_ok = wr_en && (off == EIB_RA) && !full;
    pop_ok  = rd_en && (off == EIB_RA) && !empty;
  end

  // Pending, priority and the edge latch next-state terms
  always_comb begin
    isr        = edge_lat | (irq & ~mode);
    pend       = isr & imr;
    any_pend   = |pend;
    cause      = prio_enc(32'(pend));
    cause_oh   = IRQ_COUNT'(32'd1 << cause);
    low_mask   = IRQ_COUNT'((32'd1 << cause) - 32'd1);
    edge_set   = mode & irq & ~irq_q;
    edge_clr   = '0;
    if (wr_en && (off == EIB_ISR)) edge_clr = edge_clr | wdata_n;
    if (push_ok)                   edge_clr = edge_clr | cause_oh;
    cause_word             = 32'(cause);
    cause_word[CAUSE_NONE] = ~any_pend;
  end

  // Read data source for the selected offset
  always_comb begin
    rd_mux = '0;
    case (off)
      EIB_RA:    rd_mux = empty ? 32'd0 : st_ra;
      EIB_ISR:   rd_mux = 32'(isr);
      EIB_IMR:   rd_mux = 32'(imr);
      EIB_MODE:  rd_mux = 32'(mode);
      EIB_CAUSE: rd_mux = cause_word;
      EIB_STAT:  rd_mux = 32'({ovf, unf, depth});
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imr      <= '0;
      mode     <= '0;
      edge_lat <= '0;
      irq_q    <= '0;
      depth    <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      trap     <= 1'b0;
      d_rdata  <= '0;
    end else begin
      irq_q    <= irq;
      edge_lat <= (edge_lat & ~edge_clr) | edge_set;
      trap     <= any_pend;
      if (rd_en) d_rdata <= rd_mux;
      if (wr_en) begin
        case (off)
          EIB_IMR:  imr  <= wdata_n;
          EIB_MODE: mode <= wdata_n;
          EIB_STAT: begin
            ovf <= 1'b0;
            unf <= 1'b0;
          end
          EIB_RA: begin
            if (full) begin
              ovf <= 1'b1;
            end else begin
              depth <= depth + DW'(1);
              imr   <= imr & low_mask;
            end
          end
          default: ;
        endcase
      end
      // A pop hands control back to the interrupted frame's mask
      if (rd_en && (off == EIB_RA)) begin
        if (pop_ok) begin
          depth <= depth - DW'(1);
          imr   <= st_imr;
        end else begin
          unf <= 1'b1;
        end
      end
    end
  end

  eib_frame_stack #(
    .IRQ_COUNT (IRQ_COUNT),
    .DEPTH_BITS(DEPTH_BITS)
  ) u_stack (
    .clk   (clk),
    .we    (push_ok),
    .wr_idx(depth[DEPTH_BITS-1:0]),
    .wr_ra (d_wdata),
    .wr_imr(imr),
    .rd_idx(DEPTH_BITS'(depth - DW'(1))),
    .rd_ra (st_ra),
    .rd_imr(st_imr)
  );

endmodule

// File: tb/tb_eib_nested.sv
// Directed bench for eib_nested: reads and trap probes queue their expected
// values; a monitor compares them when the DUT presents the response.
module tb_eib_nested;
  import eib_pkg::*;

  localparam int unsigned N  = 8;
  localparam logic [19:0] PG = 20'hfffff;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          strobe = 1'b0;
  logic          rw = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic [N-1:0]  irq = '0;
  logic          trap;
  logic [4:0]    cause;

  always #5 clk = ~clk;

  eib_nested #(.IRQ_COUNT(N), .DEPTH_BITS(1), .PAGE(PG)) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .rw(rw), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .irq(irq), .trap(trap), .cause(cause)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t rq[$];
  exp_t tq[$];
  int   total = 0;
  int   bad   = 0;
  logic rd_seen = 1'b0;
  logic probe = 1'b0;

  always @(posedge clk) rd_seen <= strobe && !rw && (d_addr[31:12] == PG);

  // Monitor: read data the cycle after a selected read; trap when probed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_seen) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read got=%h", d_rdata);
        end else begin
          e = rq.pop_front();
          if (d_rdata !== e.exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", e.name, d_rdata, e.exp);
          end
        end
      end
      if (probe) begin
        total++;
        if (tq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_probe trap=%b", trap);
        end else begin
          e = tq.pop_front();
          if ({31'b0, trap} !== e.exp) begin
            bad++;
            $display("FAIL %s trap got=%b want=%b", e.name, trap, e.exp[0]);
          end
        end
      end
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    strobe = 1'b1; rw = w; d_addr = a; d_wdata = d;
    @(posedge clk); #1;
    strobe = 1'b0; rw = 1'b0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    access(1'b1, {PG, off}, d);
  endtask

  task automatic rd(input logic [11:0] off, input logic [31:0] e, input string nm);
    exp_t x;
    x.name = nm; x.exp = e;
    rq.push_back(x);
    access(1'b0, {PG, off}, 32'd0);
  endtask

  task automatic chk_trap(input logic e, input string nm);
    exp_t x;
    x.name = nm; x.exp = 32'(e);
    tq.push_back(x);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(EIB_IMR,   32'h0, "rst_imr");
    rd(EIB_MODE,  32'h0, "rst_mode");
    rd(EIB_ISR,   32'h0, "rst_isr");
    rd(EIB_CAUSE, 32'h8000_0000, "rst_cause");
    rd(EIB_STAT,  32'h0, "rst_stat");
    chk_trap(1'b0, "rst_trap");

    // Level line 3
    wr(EIB_MODE, 32'h0);
    wr(EIB_IMR, 32'h0000_000c);
    irq[3] = 1'b1;
    chk_trap(1'b0, "lvl_pre");
    chk_trap(1'b1, "lvl_on");
    rd(EIB_ISR,   32'h8, "lvl_isr");
    rd(EIB_CAUSE, 32'h3, "lvl_cause");
    irq[3] = 1'b0;
    chk_trap(1'b1, "lvl_hold");
    chk_trap(1'b0, "lvl_off");

    // Edge line 0: one-cycle pulse is latched until W1C
    wr(EIB_IMR, 32'h1);
    wr(EIB_MODE, 32'h1);
    irq[0] = 1'b1;
    idle(1);
    irq[0] = 1'b0;
    idle(2);
    rd(EIB_ISR, 32'h1, "edge_isr_held");
    chk_trap(1'b1, "edge_trap");
    wr(EIB_ISR, 32'h1);
    chk_trap(1'b1, "edge_clr_lag");
    chk_trap(1'b0, "edge_clr_trap");
    rd(EIB_ISR, 32'h0, "edge_isr_clr");

    // W1C and a fresh rising edge on line 4 in the same cycle
    wr(EIB_MODE, 32'h11);
    irq[4] = 1'b1;
    idle(1);
    irq[4] = 1'b0;
    idle(1);
    rd(EIB_ISR, 32'h10, "sim_isr_pre");
    @(posedge clk); #1;
    strobe = 1'b1; rw = 1'b1; d_addr = {PG, EIB_ISR}; d_wdata = 32'h10; irq[4] = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0; rw = 1'b0; irq[4] = 1'b0;
    rd(EIB_ISR, 32'h10, "sim_set_wins");
    wr(EIB_ISR, 32'h10);
    rd(EIB_ISR, 32'h0, "sim_isr_clr");

    // Nesting with level lines 5 and 2, then 1
    wr(EIB_MODE, 32'h0);
    irq = 8'h24;
    wr(EIB_IMR, 32'hff);
    rd(EIB_CAUSE, 32'h2, "nest_cause2");
    chk_trap(1'b1, "nest_trap");
    wr(EIB_RA, 32'h100);
    chk_trap(1'b1, "push_lag");
    chk_trap(1'b0, "push_drop");
    rd(EIB_IMR,   32'h03, "push1_imr");
    rd(EIB_STAT,  32'h1, "push1_stat");
    rd(EIB_CAUSE, 32'h8000_0000, "push1_cause");
    irq[1] = 1'b1;
    rd(EIB_CAUSE, 32'h1, "nest_cause1");
    wr(EIB_RA, 32'h200);
    rd(EIB_IMR,  32'h01, "push2_imr");
    rd(EIB_STAT, 32'h2, "push2_stat");

    // Overflow at MAX_DEPTH=2, then unwind past empty
    wr(EIB_RA, 32'h300);
    rd(EIB_STAT, 32'hA, "ovf_stat");
    rd(EIB_IMR,  32'h01, "ovf_imr");
    rd(EIB_RA,   32'h200, "pop1_ra");
    rd(EIB_IMR,  32'h03, "pop1_imr");
    rd(EIB_RA,   32'h100, "pop2_ra");
    rd(EIB_IMR,  32'hff, "pop2_imr");
    rd(EIB_STAT, 32'h8, "pop2_stat");
    rd(EIB_RA,   32'h0, "unf_ra");
    rd(EIB_STAT, 32'hC, "unf_stat");
    rd(EIB_IMR,  32'hff, "unf_imr");
    wr(EIB_STAT, 32'h0);
    rd(EIB_STAT, 32'h0, "stat_clr");

    // Width limits, unmapped offset, foreign page
    irq = '0;
    wr(EIB_IMR, 32'hffff_ffff);
    rd(EIB_IMR, 32'hff, "imr_width");
    wr(EIB_MODE, 32'hffff_ff00);
    rd(EIB_MODE, 32'h0, "mode_width");
    rd(12'h000, 32'h0, "unmapped");
    access(1'b1, {20'h12345, EIB_IMR}, 32'h0);
    rd(EIB_IMR, 32'hff, "other_page");

    idle(3);
    if (rq.size() != 0 || tq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain reads_left=%0d probes_left=%0d want=0", rq.size(), tq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
